// File: rtl/rs_issue_scheduler.sv
// ----------------------------------------------------------------------------
// rs_issue_scheduler
//
// Sequencing controller for the reservation-station entry array. It owns the
// per-entry occupancy state, hands free slots to the decoder and selects one
// operand-ready entry per cycle for issue to the ALU. Selection is round-robin,
// starting at the entry after the most recently issued one.
//
// Ports:
//   clk_in       system clock, rising edge
//   rst_in       asynchronous, active-high reset
//   rdy_in       global enable; when low every piece of state holds
//   flush_in     RoB mispredict flush (synchronous)
//   alloc_req    decoder requests a slot
//   alloc_grant  slot granted this cycle (combinational)
//   alloc_idx    granted slot index, 0 when there is no grant (combinational)
//   entry_ready  per-entry "both operands resolved" from the RS
//   issue_valid  registered issue request to the ALU
//   issue_idx    registered index of the entry being issued
//   alu_ready    ALU accepts the current issue
//   rs_full      every entry is busy
//   rs_count     number of busy entries (registered)
// ----------------------------------------------------------------------------
module rs_issue_scheduler #(
    parameter int unsigned RS_SIZE = 16,
    parameter int unsigned IDX_W   = 4
) (
    input  logic               clk_in,
    input  logic               rst_in,
    input  logic               rdy_in,
    input  logic               flush_in,
    input  logic               alloc_req,
    output logic               alloc_grant,
    output logic [IDX_W-1:0]   alloc_idx,
    input  logic [RS_SIZE-1:0] entry_ready,
    output logic               issue_valid,
    output logic [IDX_W-1:0]   issue_idx,
    input  logic               alu_ready,
    output logic               rs_full,
    output logic [IDX_W:0]     rs_count
);

    localparam logic [IDX_W:0] FullCount = (IDX_W+1)'(RS_SIZE);

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    logic [RS_SIZE-1:0] busy_q, busy_d;
    // Entry has already been loaded into the issue register and must not be
    // picked again until it is accepted or reallocated.
    logic [RS_SIZE-1:0] issued_q, issued_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic               issue_valid_q, issue_valid_d;
    logic [IDX_W-1:0]   issue_idx_q, issue_idx_d;
    logic [IDX_W:0]     count_q, count_d;

    // ------------------------------------------------------------------------
    // Control terms
    // ------------------------------------------------------------------------
    logic               accept;
    logic               load;
    logic               grant;
    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic [RS_SIZE-1:0] cand;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic [IDX_W-1:0]   probe;

    assign rs_full = (count_q == FullCount);
    assign accept  = issue_valid_q & alu_ready & rdy_in;
    assign load    = rdy_in & (~issue_valid_q | accept);
    assign grant   = rdy_in & alloc_req & ~rs_full & ~flush_in;

    // Lowest free slot, judged from busy at the start of the cycle so that a
    // slot freed by an accept this cycle cannot be handed out until the next.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            if (!free_found && !busy_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    // Candidates come from registered busy, so a slot allocated this cycle
    // only becomes eligible on the next one.
    assign cand = busy_q & ~issued_q & entry_ready;

    // Round-robin pick: scan from rr_ptr upwards; the IDX_W-bit sum wraps
    // modulo RS_SIZE because RS_SIZE is a power of two.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        probe     = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            probe = rr_ptr_q + IDX_W'(i);
            if (!sel_found && cand[probe]) begin
                sel_found = 1'b1;
                sel_idx   = probe;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state
    // ------------------------------------------------------------------------
    always_comb begin
        busy_d        = busy_q;
        issued_d      = issued_q;
        rr_ptr_d      = rr_ptr_q;
        issue_valid_d = issue_valid_q;
        issue_idx_d   = issue_idx_q;

        if (rdy_in) begin
            if (flush_in) begin
                // An accept in the flush cycle still reaches the ALU; the RoB
                // drops its result, so nothing here needs to honour it.
                busy_d        = '0;
                issued_d      = '0;
                rr_ptr_d      = '0;
                issue_valid_d = 1'b0;
            end else begin
                // The three index updates never collide: the accepted entry is
                // issued, the selected entry is not, and the granted entry is
                // not busy.
                if (accept) begin
                    busy_d[issue_idx_q]   = 1'b0;
                    issued_d[issue_idx_q] = 1'b0;
                end
                if (grant) begin
                    busy_d[free_idx]   = 1'b1;
                    issued_d[free_idx] = 1'b0;
                end
                if (load) begin
                    if (sel_found) begin
                        issue_valid_d     = 1'b1;
                        issue_idx_d       = sel_idx;
                        issued_d[sel_idx] = 1'b1;
                        rr_ptr_d          = sel_idx + IDX_W'(1);
                    end else begin
                        issue_valid_d = 1'b0;
                    end
                end
            end
        end
    end

    // Occupancy is the popcount of the next busy vector, so it always tracks
    // busy exactly (grant and accept in one cycle cancel out).
    always_comb begin
        count_d = '0;
        for (int i = 0; i < int'(RS_SIZE); i++) begin
            count_d = count_d + {{IDX_W{1'b0}}, busy_d[i]};
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy_q        <= '0;
            issued_q      <= '0;
            rr_ptr_q      <= '0;
            issue_valid_q <= 1'b0;
            issue_idx_q   <= '0;
            count_q       <= '0;
        end else begin
            busy_q        <= busy_d;
            issued_q      <= issued_d;
            rr_ptr_q      <= rr_ptr_d;
            issue_valid_q <= issue_valid_d;
            issue_idx_q   <= issue_idx_d;
            count_q       <= count_d;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign alloc_grant = grant;
    assign alloc_idx   = grant ? free_idx : '0;
    assign issue_valid = issue_valid_q;
    assign issue_idx   = issue_idx_q;
    assign rs_count    = count_q;

endmodule

// File: tb/tb_rs_issue_scheduler.sv
// ----------------------------------------------------------------------------
// tb_rs_issue_scheduler
//
// Bench for rs_issue_scheduler. A behavioural model (plain arrays) predicts
// every output each cycle; directed scenarios add literal expectations, then
// a long randomized run exercises the same model.
// ----------------------------------------------------------------------------
module tb_rs_issue_scheduler;

    localparam int N = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic        rdy_in;
    logic        flush_in;
    logic        alloc_req;
    logic        alloc_grant;
    logic [3:0]  alloc_idx;
    logic [15:0] entry_ready;
    logic        issue_valid;
    logic [3:0]  issue_idx;
    logic        alu_ready;
    logic        rs_full;
    logic [4:0]  rs_count;

    rs_issue_scheduler #(
        .RS_SIZE (16),
        .IDX_W   (4)
    ) dut (
        .clk_in      (clk_in),
        .rst_in      (rst_in),
        .rdy_in      (rdy_in),
        .flush_in    (flush_in),
        .alloc_req   (alloc_req),
        .alloc_grant (alloc_grant),
        .alloc_idx   (alloc_idx),
        .entry_ready (entry_ready),
        .issue_valid (issue_valid),
        .issue_idx   (issue_idx),
        .alu_ready   (alu_ready),
        .rs_full     (rs_full),
        .rs_count    (rs_count)
    );

    always #5 clk_in = ~clk_in;

    int total = 0;
    int bad   = 0;

    // Behavioural model
    bit m_busy   [N];
    bit m_issued [N];
    int m_rr;
    bit m_iv;
    int m_iidx;

    // Values sampled in the most recent cycle
    int s_grant, s_aidx, s_iv, s_iidx, s_count, s_full;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int m_cnt();
        int c = 0;
        for (int i = 0; i < N; i++) c += m_busy[i];
        return c;
    endfunction

    function automatic int m_lowest_free();
        for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_busy[i]   = 0;
            m_issued[i] = 0;
        end
        m_rr   = 0;
        m_iv   = 0;
        m_iidx = 0;
    endtask

    task automatic model_step(input bit rdy, input bit fl, input bit areq, input bit ar,
                              input logic [15:0] er);
        bit acc, g, ld, found;
        int gi, sel;
        if (!rdy) return;
        if (fl) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i]   = 0;
                m_issued[i] = 0;
            end
            m_rr = 0;
            m_iv = 0;
            return;
        end
        acc   = m_iv && ar;
        g     = areq && (m_cnt() != N);
        gi    = m_lowest_free();
        ld    = !m_iv || acc;
        found = 0;
        sel   = 0;
        for (int k = 0; k < N; k++) begin
            int e = (m_rr + k) % N;
            if (!found && m_busy[e] && !m_issued[e] && er[e]) begin
                found = 1;
                sel   = e;
            end
        end
        if (acc) begin
            m_busy[m_iidx]   = 0;
            m_issued[m_iidx] = 0;
        end
        if (g) begin
            m_busy[gi]   = 1;
            m_issued[gi] = 0;
        end
        if (ld) begin
            if (found) begin
                m_iv         = 1;
                m_iidx       = sel;
                m_issued[sel] = 1;
                m_rr         = (sel + 1) % N;
            end else begin
                m_iv = 0;
            end
        end
    endtask

    task automatic compare_model();
        int c  = m_cnt();
        int g  = (rdy_in && alloc_req && !flush_in && c != N) ? 1 : 0;
        int gi = g ? m_lowest_free() : 0;
        chk("alloc_grant", alloc_grant, g);
        chk("alloc_idx",   alloc_idx,   gi);
        chk("issue_valid", issue_valid, m_iv);
        chk("issue_idx",   issue_idx,   m_iidx);
        chk("rs_count",    rs_count,    c);
        chk("rs_full",     rs_full,     (c == N) ? 1 : 0);
    endtask

    task automatic cyc(input bit rdy, input bit fl, input bit areq, input bit ar,
                       input logic [15:0] er);
        @(negedge clk_in);
        rdy_in      = rdy;
        flush_in    = fl;
        alloc_req   = areq;
        alu_ready   = ar;
        entry_ready = er;
        #1;
        compare_model();
        s_grant = alloc_grant;
        s_aidx  = alloc_idx;
        s_iv    = issue_valid;
        s_iidx  = issue_idx;
        s_count = rs_count;
        s_full  = rs_full;
        @(posedge clk_in);
        model_step(rdy, fl, areq, ar, er);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_in      = 1'b1;
        rdy_in      = 1'b0;
        flush_in    = 1'b0;
        alloc_req   = 1'b0;
        alu_ready   = 1'b0;
        entry_ready = '0;
        model_reset();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        #1;
        chk("rst_issue_valid", issue_valid, 0);
        chk("rst_issue_idx",   issue_idx,   0);
        chk("rst_count",       rs_count,    0);
        chk("rst_full",        rs_full,     0);
        rst_in = 1'b0;

        // Three allocations take the lowest slots in order
        cyc(1, 0, 1, 0, 16'h0); chk("alloc0", s_aidx, 0); chk("grant0", s_grant, 1);
        cyc(1, 0, 1, 0, 16'h0); chk("alloc1", s_aidx, 1);
        cyc(1, 0, 1, 0, 16'h0); chk("alloc2", s_aidx, 2);
        cyc(1, 0, 1, 0, 16'h0); chk("count3", s_count, 3); chk("iv_idle", s_iv, 0);
        chk("alloc3", s_aidx, 3);

        // Round-robin issue of 0..3 back to back
        cyc(1, 0, 0, 1, 16'hF); chk("rr_count4", s_count, 4);
        cyc(1, 0, 0, 1, 16'hF); chk("rr_i0", s_iidx, 0); chk("rr_v0", s_iv, 1);
        cyc(1, 0, 0, 1, 16'hF); chk("rr_i1", s_iidx, 1);
        cyc(1, 0, 0, 1, 16'hF); chk("rr_i2", s_iidx, 2);
        cyc(1, 0, 0, 1, 16'hF); chk("rr_i3", s_iidx, 3);
        cyc(1, 0, 0, 1, 16'h0); chk("rr_empty", s_iv, 0); chk("rr_count0", s_count, 0);

        // Refill 0..5; with the pointer at 4, entry 5 goes before entry 0
        repeat (6) cyc(1, 0, 1, 0, 16'h0);
        chk("refill_last", s_aidx, 5);
        cyc(1, 0, 0, 0, 16'h0021);
        cyc(1, 0, 0, 1, 16'h0021); chk("refill_first5", s_iidx, 5);
        cyc(1, 0, 0, 0, 16'h0021); chk("refill_then0", s_iidx, 0);
        cyc(1, 0, 1, 0, 16'h0);    chk("refill_reuse5", s_aidx, 5);

        // Flush together with an allocation request
        cyc(1, 1, 1, 0, 16'h0);
        chk("flush_grant", s_grant, 0); chk("flush_pre_count", s_count, 6);
        chk("flush_pre_iv", s_iv, 1);
        cyc(1, 0, 0, 0, 16'h0);
        chk("flush_count", s_count, 0); chk("flush_iv", s_iv, 0);

        // Stall with entry 2 in the issue register while entry 3 becomes ready
        repeat (4) cyc(1, 0, 1, 0, 16'h0);
        cyc(1, 0, 0, 1, 16'h7);
        cyc(1, 0, 0, 1, 16'h7); chk("st_i0", s_iidx, 0);
        cyc(1, 0, 0, 1, 16'h7); chk("st_i1", s_iidx, 1);
        for (int k = 0; k < 5; k++) begin
            cyc(1, 0, 0, 0, 16'hF); chk("st_hold", s_iidx, 2); chk("st_hold_v", s_iv, 1);
        end
        cyc(1, 0, 0, 1, 16'hF); chk("st_release", s_iidx, 2);
        cyc(1, 0, 0, 0, 16'hF); chk("st_next3", s_iidx, 3);
        cyc(1, 1, 0, 0, 16'h0);

        // Fill all entries, then free 7 and reuse it the following cycle
        repeat (16) cyc(1, 0, 1, 0, 16'h0);
        cyc(1, 0, 1, 0, 16'h0080);
        chk("full_flag", s_full, 1); chk("full_nogrant", s_grant, 0); chk("full_count", s_count, 16);
        cyc(1, 0, 1, 1, 16'h0080);
        chk("full_iss7", s_iidx, 7); chk("full_same_cycle", s_grant, 0);
        cyc(1, 0, 1, 0, 16'h0);
        chk("freed_full", s_full, 0); chk("freed_grant", s_grant, 1); chk("freed_idx7", s_aidx, 7);

        // rdy_in low freezes everything
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 1, 1, 16'hFFFF);
            chk("rdy_grant", s_grant, 0); chk("rdy_count", s_count, 16);
        end

        // Asynchronous reset between edges
        cyc(1, 0, 0, 0, 16'hFFFF);
        @(negedge clk_in);
        rdy_in = 1'b0;
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_iv",    issue_valid, 0);
        chk("arst_count", rs_count,    0);
        chk("arst_full",  rs_full,     0);
        chk("arst_idx",   issue_idx,   0);
        model_reset();
        @(negedge clk_in);
        rst_in = 1'b0;

        // Randomized run against the model
        for (int k = 0; k < 3000; k++) begin
            cyc(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) == 0),
                ($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 6),
                16'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
